decode_stage: RTL and testbench

Registered RV32 decode stage between fetch and register-read/execute, with a valid/ready handshake on both sides.
- Wraps a combinational decoder and adds a parametrised output buffer: a single pipeline register, or a 2-entry skid buffer.
- Adds pipeline flush, full immediate generation, optional M-extension decode and stricter illegal-instruction checks.
- Emits one decoded bundle per accepted instruction word, in order.

---
 rtl/decode_pkg.sv | 63 ++++++
 rtl/decode_if.sv | 38 +++
 rtl/decode_comb.sv | 157 +++++++++++++++
 rtl/decode_stage.sv | 167 ++++++++++++++++
 tb/tb_decode_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared RV32 decode definitions: opcode constants, immediate kinds, decoded bundle layout.
package decode_pkg;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ, ImmZ} imm_type_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [11:0] csr;
        logic [1:0]  access_size;
        logic        rd_en;
        logic        rs1_en;
        logic        rs2_en;
        logic        imm_en;
        logic        alu_en;
        logic        alu_flag;
        logic        mem_en;
        logic        rw;
        logic        unsign;
        logic        is_jal;
        logic        is_jalr;
        logic        is_branch;
        logic        is_jmp;
        logic        is_fence;
        logic        is_system;
        logic        is_muldiv;
        logic        is_invalid;
    } bundle_t;

    localparam int unsigned BUNDLE_W = $bits(bundle_t);

    function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_type_e sel);
        logic [31:0] imm;
        unique case (sel)
            ImmI:    imm = {{20{inst[31]}}, inst[31:20]};
            ImmS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            ImmB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            ImmU:    imm = {inst[31:12], 12'h000};
            ImmJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            ImmZ:    imm = {27'd0, inst[19:15]};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and consumer-side handshake plus decoded bundle fields of the decode stage.
interface decode_if #(
    parameter int unsigned PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [31:0]     imm;
    logic [11:0]     csr;
    logic [1:0]      access_size;
    logic            rd_en, rs1_en, rs2_en, imm_en, alu_en, alu_flag, mem_en, rw, unsign;
    logic            is_jal, is_jalr, is_branch, is_jmp, is_fence, is_system, is_muldiv;
    logic            is_invalid;

    modport master (
        output in_valid, inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, rd, rs1, rs2, funct3, imm, csr, access_size,
        input  rd_en, rs1_en, rs2_en, imm_en, alu_en, alu_flag, mem_en, rw, unsign,
        input  is_jal, is_jalr, is_branch, is_jmp, is_fence, is_system, is_muldiv, is_invalid
    );

    modport slave (
        input  in_valid, inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, rd, rs1, rs2, funct3, imm, csr, access_size,
        output rd_en, rs1_en, rs2_en, imm_en, alu_en, alu_flag, mem_en, rw, unsign,
        output is_jal, is_jalr, is_branch, is_jmp, is_fence, is_system, is_muldiv, is_invalid
    );

endinterface

// File: rtl/decode_comb.sv
// Pure combinational RV32I(+M, +Zicsr) instruction decoder producing one bundle_t.
module decode_comb
    import decode_pkg::*;
#(
    parameter bit EN_M     = 1'b0,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic [31:0] inst_i,
    output bundle_t     dec_o
);

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       illegal;
    imm_type_e  imm_t;
    bundle_t    d;

    assign opc = inst_i[6:2];
    assign f3  = inst_i[14:12];
    assign f7  = inst_i[31:25];

    always_comb begin
        d         = '0;
        illegal   = 1'b0;
        imm_t     = ImmI;
        d.rd      = inst_i[11:7];
        d.rs1     = inst_i[19:15];
        d.rs2     = inst_i[24:20];
        d.funct3  = f3;
        d.csr     = inst_i[31:20];

        if (inst_i[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            unique case (opc)
                OPC_LUI: begin
                    d.rs1    = 5'd0;
                    d.rd_en  = 1'b1;
                    d.imm_en = 1'b1;
                    d.alu_en = 1'b1;
                    imm_t    = ImmU;
                end
                OPC_AUIPC: begin
                    d.rd_en  = 1'b1;
                    d.imm_en = 1'b1;
                    d.alu_en = 1'b1;
                    imm_t    = ImmU;
                end
                OPC_JAL: begin
                    d.rd_en  = 1'b1;
                    d.imm_en = 1'b1;
                    d.is_jal = 1'b1;
                    imm_t    = ImmJ;
                end
                OPC_JALR: begin
                    illegal   = (f3 != 3'b000);
                    d.rd_en   = 1'b1;
                    d.rs1_en  = 1'b1;
                    d.imm_en  = 1'b1;
                    d.is_jalr = 1'b1;
                end
                OPC_BRANCH: begin
                    illegal     = (f3[2:1] == 2'b01);
                    d.rs1_en    = 1'b1;
                    d.rs2_en    = 1'b1;
                    d.imm_en    = 1'b1;
                    d.is_branch = 1'b1;
                    imm_t       = ImmB;
                end
                OPC_LOAD, OPC_STORE: begin
                    // Loads reject lwu/ld-style widths; stores only support b/h/w.
                    if (opc == OPC_LOAD) begin
                        illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
                        d.rd_en = 1'b1;
                    end else begin
                        illegal  = (f3 >= 3'b011);
                        d.rs2_en = 1'b1;
                        imm_t    = ImmS;
                    end
                    d.rs1_en      = 1'b1;
                    d.imm_en      = 1'b1;
                    d.mem_en      = 1'b1;
                    d.rw          = ~inst_i[5];
                    d.unsign      = inst_i[14];
                    d.access_size = inst_i[13:12];
                end
                OPC_OP_IMM: begin
                    if (f3 == 3'b001) begin
                        illegal = (f7 != 7'b0000000);
                    end else if (f3 == 3'b101) begin
                        illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    end
                    d.rd_en    = 1'b1;
                    d.rs1_en   = 1'b1;
                    d.imm_en   = 1'b1;
                    d.alu_en   = 1'b1;
                    d.alu_flag = (f3 == 3'b101) && inst_i[30];
                end
                OPC_OP: begin
                    d.rd_en  = 1'b1;
                    d.rs1_en = 1'b1;
                    d.rs2_en = 1'b1;
                    d.alu_en = 1'b1;
                    if (f7 == 7'b0000001) begin
                        if (EN_M) begin
                            d.is_muldiv = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
                    end else if (f7 == 7'b0000000) begin
                        d.alu_flag = 1'b0;
                    end else if (f7 == 7'b0100000) begin
                        d.alu_flag = 1'b1;
                        illegal    = (f3 != 3'b000) && (f3 != 3'b101);
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OPC_MISC_MEM: begin
                    d.is_fence = 1'b1;
                end
                OPC_SYSTEM: begin
                    d.is_system = 1'b1;
                    if (f3 == 3'b100) begin
                        illegal = 1'b1;
                    end else if (f3 != 3'b000) begin
                        illegal = !EN_ZICSR;
                        d.rd_en = 1'b1;
                        // funct3[2] selects the zimm form over the rs1 form.
                        if (f3[2]) begin
                            d.imm_en = 1'b1;
                            imm_t    = ImmZ;
                        end else begin
                            d.rs1_en = 1'b1;
                        end
                    end
                end
                default: illegal = 1'b1;
            endcase
        end

        d.imm    = d.imm_en ? gen_imm(inst_i, imm_t) : 32'd0;
        d.rd_en  = d.rd_en && (d.rd != 5'd0);
        d.is_jmp = d.is_jal || d.is_jalr || d.is_branch;

        if (illegal) begin
            d            = '0;
            d.is_invalid = 1'b1;
        end else if (inst_i == NOP_INST) begin
            d = '0;
        end
    end

    assign dec_o = d;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_comb followed by a single output register or 2-entry skid buffer.
module decode_stage
    import decode_pkg::*;
#(
    parameter bit          SKID     = 1'b1,
    parameter bit          EN_M     = 1'b0,
    parameter bit          EN_ZICSR = 1'b1,
    parameter int unsigned PC_W     = 32
) (
    input  logic   clk,
    input  logic   nreset,
    input  logic   flush,
    decode_if.slave bus
);

    localparam int unsigned EntryW = BUNDLE_W + PC_W;

    bundle_t             dec_new;
    bundle_t             out_dec;
    logic [EntryW-1:0]   entry_new;
    logic [EntryW-1:0]   out_entry;
    logic                out_valid_w;
    logic                in_ready_w;

    decode_comb #(
        .EN_M     (EN_M),
        .EN_ZICSR (EN_ZICSR)
    ) u_decode_comb (
        .inst_i (bus.inst),
        .dec_o  (dec_new)
    );

    assign entry_new = {dec_new, bus.in_pc};

    if (SKID == 1'b0) begin : g_reg
        logic [EntryW-1:0] head_q, head_d;
        logic              valid_q, valid_d;
        logic              accept;

        assign in_ready_w = !valid_q || bus.out_ready;

        always_comb begin
            accept  = bus.in_valid && in_ready_w && !flush;
            head_d  = head_q;
            valid_d = valid_q;
            if (flush) begin
                valid_d = 1'b0;
            end else if (accept) begin
                valid_d = 1'b1;
                head_d  = entry_new;
            end else if (bus.out_ready) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                valid_q <= 1'b0;
                head_q  <= '0;
            end else begin
                valid_q <= valid_d;
                head_q  <= head_d;
            end
        end

        assign out_valid_w = valid_q;
        assign out_entry   = head_q;
    end else begin : g_skid
        typedef enum logic [1:0] {StEmpty, StOne, StFull} cnt_e;

        cnt_e              cnt_q, cnt_d;
        logic [EntryW-1:0] head_q, head_d, skid_q, skid_d;
        logic              ready_q, ready_d, valid_q, valid_d;
        logic              accept, drain;

        always_comb begin
            accept = bus.in_valid && ready_q && !flush;
            drain  = valid_q && bus.out_ready && !flush;
            cnt_d  = cnt_q;
            head_d = head_q;
            skid_d = skid_q;
            if (flush) begin
                cnt_d = StEmpty;
            end else begin
                unique case (cnt_q)
                    StEmpty: begin
                        if (accept) begin
                            head_d = entry_new;
                            cnt_d  = StOne;
                        end
                    end
                    StOne: begin
                        if (accept && drain) begin
                            head_d = entry_new;
                        end else if (accept) begin
                            skid_d = entry_new;
                            cnt_d  = StFull;
                        end else if (drain) begin
                            cnt_d = StEmpty;
                        end
                    end
                    StFull: begin
                        // Head leaves; the older skid entry moves up to keep FIFO order.
                        if (drain) begin
                            head_d = skid_q;
                            cnt_d  = StOne;
                        end
                    end
                    default: cnt_d = StEmpty;
                endcase
            end
            ready_d = (cnt_d != StFull);
            valid_d = (cnt_d != StEmpty);
        end

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                cnt_q   <= StEmpty;
                head_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                head_q  <= head_d;
                skid_q  <= skid_d;
                ready_q <= ready_d;
                valid_q <= valid_d;
            end
        end

        assign in_ready_w  = ready_q;
        assign out_valid_w = valid_q;
        assign out_entry   = head_q;
    end

    assign out_dec = out_entry[EntryW-1:PC_W];

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = out_valid_w;
    assign bus.out_pc      = out_entry[PC_W-1:0];
    assign bus.rd          = out_dec.rd;
    assign bus.rs1         = out_dec.rs1;
    assign bus.rs2         = out_dec.rs2;
    assign bus.funct3      = out_dec.funct3;
    assign bus.imm         = out_dec.imm;
    assign bus.csr         = out_dec.csr;
    assign bus.access_size = out_dec.access_size;
    assign bus.rd_en       = out_dec.rd_en;
    assign bus.rs1_en      = out_dec.rs1_en;
    assign bus.rs2_en      = out_dec.rs2_en;
    assign bus.imm_en      = out_dec.imm_en;
    assign bus.alu_en      = out_dec.alu_en;
    assign bus.alu_flag    = out_dec.alu_flag;
    assign bus.mem_en      = out_dec.mem_en;
    assign bus.rw          = out_dec.rw;
    assign bus.unsign      = out_dec.unsign;
    assign bus.is_jal      = out_dec.is_jal;
    assign bus.is_jalr     = out_dec.is_jalr;
    assign bus.is_branch   = out_dec.is_branch;
    assign bus.is_jmp      = out_dec.is_jmp;
    assign bus.is_fence    = out_dec.is_fence;
    assign bus.is_system   = out_dec.is_system;
    assign bus.is_muldiv   = out_dec.is_muldiv;
    assign bus.is_invalid  = out_dec.is_invalid;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: u0 = single register without M, u1 = skid buffer with M.
module tb_decode_stage;

    localparam logic [31:0] I_ADDI = 32'h00A0_0093;
    localparam logic [31:0] I_ADD  = 32'h0020_81B3;
    localparam logic [31:0] I_SUB  = 32'h4020_8233;
    localparam logic [31:0] I_NOP  = 32'h0000_0013;
    localparam logic [31:0] I_MUL  = 32'h0220_8033;
    localparam logic [31:0] I_BEQ  = 32'hFE00_0EE3;
    localparam logic [31:0] I_JAL  = 32'h0000_C0EF;
    localparam logic [31:0] I_LUI  = 32'h1234_52B7;

    // {rd_en,rs1_en,rs2_en,imm_en,alu_en,alu_flag,mem_en,rw,unsign} ,
    // {is_jal,is_jalr,is_branch,is_jmp,is_fence,is_system,is_muldiv,is_invalid}
    localparam logic [16:0] F_ADDI = {9'b110110000, 8'b00000000};
    localparam logic [16:0] F_ADD  = {9'b111010000, 8'b00000000};
    localparam logic [16:0] F_SUB  = {9'b111011000, 8'b00000000};
    localparam logic [16:0] F_MUL  = {9'b011010000, 8'b00000010};
    localparam logic [16:0] F_BEQ  = {9'b011100000, 8'b00110000};
    localparam logic [16:0] F_JAL  = {9'b100100000, 8'b10010000};
    localparam logic [16:0] F_LUI  = {9'b100110000, 8'b00000000};
    localparam logic [16:0] F_SW   = {9'b011100100, 8'b00000000};
    localparam logic [16:0] F_LBU  = {9'b110100111, 8'b00000000};
    localparam logic [16:0] F_CSRI = {9'b100100000, 8'b00000100};
    localparam logic [16:0] F_CSR  = {9'b010000000, 8'b00000100};
    localparam logic [16:0] F_SRAI = {9'b110111000, 8'b00000000};
    localparam logic [16:0] F_INV  = 17'd1;

    logic clk, nreset, flush0, flush1;
    int   n_asrt, n_fail;

    decode_if #(.PC_W(32)) if0 ();
    decode_if #(.PC_W(32)) if1 ();

    decode_stage #(.SKID(1'b0), .EN_M(1'b0), .EN_ZICSR(1'b1), .PC_W(32)) u_dut0 (
        .clk(clk), .nreset(nreset), .flush(flush0), .bus(if0)
    );
    decode_stage #(.SKID(1'b1), .EN_M(1'b1), .EN_ZICSR(1'b1), .PC_W(32)) u_dut1 (
        .clk(clk), .nreset(nreset), .flush(flush1), .bus(if1)
    );

    logic [16:0] f0, f1;
    assign f0 = {if0.rd_en, if0.rs1_en, if0.rs2_en, if0.imm_en, if0.alu_en, if0.alu_flag,
                 if0.mem_en, if0.rw, if0.unsign, if0.is_jal, if0.is_jalr, if0.is_branch,
                 if0.is_jmp, if0.is_fence, if0.is_system, if0.is_muldiv, if0.is_invalid};
    assign f1 = {if1.rd_en, if1.rs1_en, if1.rs2_en, if1.imm_en, if1.alu_en, if1.alu_flag,
                 if1.mem_en, if1.rw, if1.unsign, if1.is_jal, if1.is_jalr, if1.is_branch,
                 if1.is_jmp, if1.is_fence, if1.is_system, if1.is_muldiv, if1.is_invalid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic offer0(input logic [31:0] w, input logic [31:0] pc);
        if0.inst = w; if0.in_pc = pc; if0.in_valid = 1'b1;
        @(negedge clk);
        if0.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        nreset = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
        if0.in_valid = 1'b0; if0.inst = '0; if0.in_pc = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.inst = '0; if1.in_pc = '0; if1.out_ready = 1'b0;
        #2;
        n_asrt++;
        if ({if0.out_valid, if1.out_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_valid: got %b want 00", {if0.out_valid, if1.out_valid});
        end
        n_asrt++;
        if ({f0, f1, if0.imm, if1.imm, if0.rd, if1.rd, if0.out_pc, if1.csr} !== '0) begin
            n_fail++; $display("FAIL reset_fields: got nonzero f0=%h f1=%h want 0", f0, f1);
        end
        n_asrt++;
        if ({if0.in_ready, if1.in_ready} !== 2'b10) begin
            n_fail++; $display("FAIL reset_ready: got %b want 10", {if0.in_ready, if1.in_ready});
        end
        @(negedge clk); nreset = 1'b1; #1;
        n_asrt++;
        if (if1.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL release_ready_skid: got %b want 0", if1.in_ready);
        end
        @(negedge clk);
        n_asrt++;
        if (if1.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL first_edge_ready_skid: got %b want 1", if1.in_ready);
        end
    endtask

    task automatic test_addi();
        if0.out_ready = 1'b1;
        offer0(I_ADDI, 32'h100);
        n_asrt++;
        if ({if0.out_valid, if0.rd, if0.rs1, if0.out_pc} !== {1'b1, 5'd1, 5'd0, 32'h100}) begin
            n_fail++; $display("FAIL addi_regs: got v=%b rd=%0d rs1=%0d pc=%h want 1 1 0 100",
                               if0.out_valid, if0.rd, if0.rs1, if0.out_pc);
        end
        n_asrt++;
        if (if0.imm !== 32'h0000_000A) begin
            n_fail++; $display("FAIL addi_imm: got %h want 0000000a", if0.imm);
        end
        n_asrt++;
        if (f0 !== F_ADDI) begin
            n_fail++; $display("FAIL addi_flags: got %b want %b", f0, F_ADDI);
        end
        @(negedge clk);
        n_asrt++;
        if (if0.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL addi_drained: got %b want 0", if0.out_valid);
        end
    endtask

    task automatic test_hold();
        if0.out_ready = 1'b0;
        offer0(I_LUI, 32'h200);
        n_asrt++;
        if ({if0.imm, if0.rd, if0.rs1, if0.in_ready} !== {32'h1234_5000, 5'd5, 5'd0, 1'b0}) begin
            n_fail++; $display("FAIL lui_out: got imm=%h rd=%0d rs1=%0d rdy=%b want 12345000 5 0 0",
                               if0.imm, if0.rd, if0.rs1, if0.in_ready);
        end
        n_asrt++;
        if (f0 !== F_LUI) begin
            n_fail++; $display("FAIL lui_flags: got %b want %b", f0, F_LUI);
        end
        if0.inst = I_ADDI; if0.in_pc = 32'h204; if0.in_valid = 1'b1;
        @(negedge clk);
        n_asrt++;
        if ({if0.out_valid, if0.imm, if0.out_pc} !== {1'b1, 32'h1234_5000, 32'h200}) begin
            n_fail++; $display("FAIL hold_stable: got v=%b imm=%h pc=%h want 1 12345000 200",
                               if0.out_valid, if0.imm, if0.out_pc);
        end
        if0.out_ready = 1'b1;
        @(negedge clk);
        if0.in_valid = 1'b0;
        n_asrt++;
        if ({if0.out_valid, if0.imm, if0.out_pc} !== {1'b1, 32'h0000_000A, 32'h204}) begin
            n_fail++; $display("FAIL hold_next: got v=%b imm=%h pc=%h want 1 0000000a 204",
                               if0.out_valid, if0.imm, if0.out_pc);
        end
        @(negedge clk);
    endtask

    task automatic test_skid_stream();
        if1.out_ready = 1'b0;
        if1.inst = I_ADD; if1.in_pc = 32'h10; if1.in_valid = 1'b1;
        @(negedge clk);
        if1.inst = I_SUB; if1.in_pc = 32'h14;
        @(negedge clk);
        n_asrt++;
        if (if1.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL skid_full_ready: got %b want 0", if1.in_ready);
        end
        if1.inst = I_NOP; if1.in_pc = 32'h18;
        @(negedge clk);
        n_asrt++;
        if ({if1.out_valid, if1.rd, if1.out_pc, f1} !== {1'b1, 5'd3, 32'h10, F_ADD}) begin
            n_fail++; $display("FAIL skid_add: got v=%b rd=%0d pc=%h f=%b want 1 3 10 %b",
                               if1.out_valid, if1.rd, if1.out_pc, f1, F_ADD);
        end
        if1.out_ready = 1'b1;
        @(negedge clk);
        n_asrt++;
        if ({if1.out_valid, if1.rd, if1.out_pc, f1} !== {1'b1, 5'd4, 32'h14, F_SUB}) begin
            n_fail++; $display("FAIL skid_sub: got v=%b rd=%0d pc=%h f=%b want 1 4 14 %b",
                               if1.out_valid, if1.rd, if1.out_pc, f1, F_SUB);
        end
        @(negedge clk);
        if1.in_valid = 1'b0;
        n_asrt++;
        if ({if1.out_valid, if1.out_pc, f1, if1.rd, if1.rs1, if1.rs2, if1.funct3, if1.imm}
            !== {1'b1, 32'h18, 17'd0, 15'd0, 3'd0, 32'd0}) begin
            n_fail++; $display("FAIL skid_nop: got v=%b pc=%h f=%b rd=%0d imm=%h want 1 18 0 0 0",
                               if1.out_valid, if1.out_pc, f1, if1.rd, if1.imm);
        end
        @(negedge clk);
        n_asrt++;
        if (if1.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL skid_empty: got %b want 0", if1.out_valid);
        end
    endtask

    task automatic test_muldiv();
        if0.out_ready = 1'b1; if1.out_ready = 1'b1;
        if0.inst = I_MUL; if0.in_pc = 32'h30; if0.in_valid = 1'b1;
        if1.inst = I_MUL; if1.in_pc = 32'h30; if1.in_valid = 1'b1;
        @(negedge clk);
        if0.in_valid = 1'b0; if1.in_valid = 1'b0;
        n_asrt++;
        if ({if0.out_valid, f0} !== {1'b1, F_INV}) begin
            n_fail++; $display("FAIL mul_no_m: got v=%b f=%b want 1 %b", if0.out_valid, f0, F_INV);
        end
        n_asrt++;
        if ({if1.out_valid, f1, if1.rd} !== {1'b1, F_MUL, 5'd0}) begin
            n_fail++; $display("FAIL mul_with_m: got v=%b f=%b rd=%0d want 1 %b 0",
                               if1.out_valid, f1, if1.rd, F_MUL);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        if1.out_ready = 1'b0;
        if1.inst = I_ADD; if1.in_pc = 32'h10; if1.in_valid = 1'b1;
        @(negedge clk);
        if1.inst = I_SUB; if1.in_pc = 32'h14;
        @(negedge clk);
        if1.inst = I_JAL; if1.in_pc = 32'h40; flush1 = 1'b1;
        if0.out_ready = 1'b1; if0.inst = I_JAL; if0.in_pc = 32'h40; if0.in_valid = 1'b1;
        flush0 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0; flush0 = 1'b0; if1.in_valid = 1'b0; if0.in_valid = 1'b0;
        n_asrt++;
        if ({if1.out_valid, if1.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL flush_full: got v=%b rdy=%b want 0 1",
                               if1.out_valid, if1.in_ready);
        end
        n_asrt++;
        if (if0.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_beats_accept: got %b want 0", if0.out_valid);
        end
        if1.out_ready = 1'b1;
        @(negedge clk);
        n_asrt++;
        if (if1.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_stale: got %b want 0", if1.out_valid);
        end
        if1.inst = I_ADDI; if1.in_pc = 32'h50; if1.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        n_asrt++;
        if ({if1.out_valid, if1.out_pc, if1.rd} !== {1'b1, 32'h50, 5'd1}) begin
            n_fail++; $display("FAIL flush_refill: got v=%b pc=%h rd=%0d want 1 50 1",
                               if1.out_valid, if1.out_pc, if1.rd);
        end
        @(negedge clk);
    endtask

    task automatic test_branch_jal();
        if0.out_ready = 1'b1;
        offer0(I_BEQ, 32'h60);
        n_asrt++;
        if ({f0, if0.imm} !== {F_BEQ, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL beq: got f=%b imm=%h want %b fffffffc", f0, if0.imm, F_BEQ);
        end
        offer0(I_JAL, 32'h64);
        n_asrt++;
        if ({f0, if0.imm, if0.rd} !== {F_JAL, 32'h0000_C000, 5'd1}) begin
            n_fail++; $display("FAIL jal: got f=%b imm=%h rd=%0d want %b 0000c000 1",
                               f0, if0.imm, if0.rd, F_JAL);
        end
    endtask

    task automatic test_decode_table();
        logic [31:0] v_inst [14];
        logic [16:0] v_flg  [14];
        logic [31:0] v_imm  [14];
        v_inst[0]  = 32'h0020_A223; v_flg[0]  = F_SW;   v_imm[0]  = 32'h0000_0004;
        v_inst[1]  = 32'hFFF0_C283; v_flg[1]  = F_LBU;  v_imm[1]  = 32'hFFFF_FFFF;
        v_inst[2]  = 32'h3002_D0F3; v_flg[2]  = F_CSRI; v_imm[2]  = 32'h0000_0005;
        v_inst[3]  = 32'h3000_1073; v_flg[3]  = F_CSR;  v_imm[3]  = 32'h0000_0000;
        v_inst[4]  = 32'h4031_5093; v_flg[4]  = F_SRAI; v_imm[4]  = 32'h0000_0403;
        v_inst[5]  = 32'h0000_0001; v_flg[5]  = F_INV;  v_imm[5]  = 32'h0;
        v_inst[6]  = 32'h0000_3003; v_flg[6]  = F_INV;  v_imm[6]  = 32'h0;
        v_inst[7]  = 32'h4000_1033; v_flg[7]  = F_INV;  v_imm[7]  = 32'h0;
        v_inst[8]  = 32'h0000_4073; v_flg[8]  = F_INV;  v_imm[8]  = 32'h0;
        v_inst[9]  = 32'h4031_1093; v_flg[9]  = F_INV;  v_imm[9]  = 32'h0;
        v_inst[10] = 32'h0000_2063; v_flg[10] = F_INV;  v_imm[10] = 32'h0;
        v_inst[11] = 32'h0000_3023; v_flg[11] = F_INV;  v_imm[11] = 32'h0;
        v_inst[12] = 32'h0000_007F; v_flg[12] = F_INV;  v_imm[12] = 32'h0;
        v_inst[13] = 32'h0000_1067; v_flg[13] = F_INV;  v_imm[13] = 32'h0;
        if0.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            offer0(v_inst[i], 32'h1000 + 32'(i));
            n_asrt++;
            if ({if0.out_valid, f0, if0.imm} !== {1'b1, v_flg[i], v_imm[i]}) begin
                n_fail++; $display("FAIL table_%0d: got v=%b f=%b imm=%h want 1 %b %h",
                                   i, if0.out_valid, f0, if0.imm, v_flg[i], v_imm[i]);
            end
            if (i == 2) begin
                n_asrt++;
                if ({if0.csr, if0.rd} !== {12'h300, 5'd1}) begin
                    n_fail++; $display("FAIL csrrwi_csr: got csr=%h rd=%0d want 300 1",
                                       if0.csr, if0.rd);
                end
            end
            if (i == 1) begin
                n_asrt++;
                if (if0.access_size !== 2'd0) begin
                    n_fail++; $display("FAIL lbu_size: got %0d want 0", if0.access_size);
                end
            end
            if (i == 0) begin
                n_asrt++;
                if (if0.access_size !== 2'd2) begin
                    n_fail++; $display("FAIL sw_size: got %0d want 2", if0.access_size);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_async();
        if0.out_ready = 1'b0; if1.out_ready = 1'b0;
        if0.inst = I_ADDI; if0.in_pc = 32'h70; if0.in_valid = 1'b1;
        if1.inst = I_ADDI; if1.in_pc = 32'h70; if1.in_valid = 1'b1;
        @(negedge clk);
        if0.in_valid = 1'b0; if1.in_valid = 1'b0;
        n_asrt++;
        if ({if0.out_valid, if1.out_valid} !== 2'b11) begin
            n_fail++; $display("FAIL pre_reset_valid: got %b want 11", {if0.out_valid, if1.out_valid});
        end
        #2; nreset = 1'b0; #1;
        n_asrt++;
        if ({if0.out_valid, if1.out_valid, f0, f1, if0.imm, if1.imm, if0.rd, if1.out_pc} !== '0) begin
            n_fail++; $display("FAIL async_reset_clear: got v=%b%b f0=%b f1=%b want all 0",
                               if0.out_valid, if1.out_valid, f0, f1);
        end
        n_asrt++;
        if ({if0.in_ready, if1.in_ready} !== 2'b10) begin
            n_fail++; $display("FAIL async_reset_ready: got %b want 10", {if0.in_ready, if1.in_ready});
        end
        @(negedge clk); nreset = 1'b1; #1;
        n_asrt++;
        if ({if0.in_ready, if1.in_ready} !== 2'b10) begin
            n_fail++; $display("FAIL release2_ready: got %b want 10", {if0.in_ready, if1.in_ready});
        end
        @(negedge clk);
        n_asrt++;
        if ({if0.in_ready, if1.in_ready, if1.out_valid} !== 3'b110) begin
            n_fail++; $display("FAIL release2_edge: got %b want 110",
                               {if0.in_ready, if1.in_ready, if1.out_valid});
        end
    endtask

    initial begin
        n_asrt = 0;
        n_fail = 0;
        test_reset();
        test_addi();
        test_hold();
        test_skid_stream();
        test_muldiv();
        test_flush();
        test_branch_jal();
        test_decode_table();
        test_reset_async();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
